// File: rtl/clkdiv_gate_ctrl.sv
// Programmable integer clock divider with glitch-free run gating.
// Every output is driven by a flop, and ratio changes take effect only at a period boundary.
//   state | meaning
//   IDLE  | Z held low, CNT held at 0, ratio writes go straight to the active ratio
//   RUN   | producing full N-cycle periods; ratio writes are parked as pending
module clkdiv_gate_ctrl #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic         CLK,
  input  logic         RN,
  input  logic         EN,
  input  logic [W-1:0] DIV,
  input  logic         CFG_VALID,
  output logic         CFG_READY,
  output logic         Z,
  output logic         TICK,
  output logic         ACTIVE
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] ratio_q, ratio_d;
  logic [W-1:0] pend_q, pend_d;
  logic         pend_vld_q, pend_vld_d;
  logic         ready_q, ready_d;
  logic         z_q, z_d;
  logic         tick_q, tick_d;
  logic         active_q, active_d;

  logic         accept;
  logic [W-1:0] div_clamped;
  logic [W-1:0] cnt_inc;
  logic [W-1:0] half;
  logic         at_last;

  assign accept      = CFG_VALID & ready_q;
  assign div_clamped = (DIV < W'(2)) ? W'(2) : DIV;
  assign cnt_inc     = cnt_q + W'(1);
  assign half        = ratio_q >> 1;
  assign at_last     = (cnt_q == (ratio_q - W'(1)));

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ratio_q    <= W'(DEFAULT_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      z_q        <= 1'b0;
      tick_q     <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ratio_q    <= ratio_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ready_q    <= ready_d;
      z_q        <= z_d;
      tick_q     <= tick_d;
      active_q   <= active_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ratio_d    = ratio_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ready_d    = ready_q;
    z_d        = z_q;
    tick_d     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        z_d   = 1'b0;
        if (accept) ratio_d = div_clamped;
        if (EN) begin
          state_d = RUN;
          z_d     = 1'b1;
          tick_d  = 1'b1;
        end
      end
      RUN: begin
        if (!at_last) begin
          cnt_d = cnt_inc;
          z_d   = (cnt_inc < half);
          if (accept) begin
            pend_d     = div_clamped;
            pend_vld_d = 1'b1;
            ready_d    = 1'b0;
          end
        end else if (EN) begin
          cnt_d  = '0;
          z_d    = 1'b1;
          tick_d = 1'b1;
          if (pend_vld_q) begin
            ratio_d    = pend_q;
            pend_vld_d = 1'b0;
            ready_d    = 1'b1;
          end
          // ready_q and pend_vld_q are mutually exclusive, so this never collides with the apply above
          if (accept) begin
            pend_d     = div_clamped;
            pend_vld_d = 1'b1;
            ready_d    = 1'b0;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          z_d     = 1'b0;
          if (pend_vld_q) begin
            ratio_d    = pend_q;
            pend_vld_d = 1'b0;
            ready_d    = 1'b1;
          end
          if (accept) ratio_d = div_clamped;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        z_d     = 1'b0;
      end
    endcase

    active_d = (state_d == RUN);
  end

  assign CFG_READY = ready_q;
  assign Z         = z_q;
  assign TICK      = tick_q;
  assign ACTIVE    = active_q;

endmodule

// File: tb/tb_clkdiv_gate_ctrl.sv
// Self-checking bench for clkdiv_gate_ctrl: directed scenarios plus randomized traffic
// compared against a period/position reference model.
module tb_clkdiv_gate_ctrl;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RN = 1'b0;
  logic         EN = 1'b0;
  logic [W-1:0] DIV = '0;
  logic         CFG_VALID = 1'b0;
  logic         CFG_READY, Z, TICK, ACTIVE;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: running flag, position inside the period, active ratio, pending ratios.
  bit m_run;
  int m_pos;
  int m_ratio;
  int m_pend[$];

  clkdiv_gate_ctrl #(.W(W), .DEFAULT_DIV(2)) dut (
    .CLK(CLK), .RN(RN), .EN(EN), .DIV(DIV), .CFG_VALID(CFG_VALID),
    .CFG_READY(CFG_READY), .Z(Z), .TICK(TICK), .ACTIVE(ACTIVE)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_run   = 1'b0;
    m_pos   = 0;
    m_ratio = 2;
    m_pend.delete();
  endtask

  task automatic model_edge();
    int c;
    bit acc;
    if (!RN) begin
      model_reset();
      return;
    end
    c   = (int'(DIV) < 2) ? 2 : int'(DIV);
    acc = CFG_VALID && (m_pend.size() == 0);
    if (!m_run) begin
      if (acc) m_ratio = c;
      if (EN) begin
        m_run = 1'b1;
        m_pos = 0;
      end
    end else if (m_pos < m_ratio - 1) begin
      m_pos++;
      if (acc) m_pend.push_back(c);
    end else if (EN) begin
      if (m_pend.size() != 0) m_ratio = m_pend.pop_front();
      m_pos = 0;
      if (acc) m_pend.push_back(c);
    end else begin
      m_run = 1'b0;
      m_pos = 0;
      if (m_pend.size() != 0) m_ratio = m_pend.pop_front();
      if (acc) m_ratio = c;
    end
  endtask

  function automatic logic [3:0] model_out();
    logic ez, et, ea, er;
    ez = m_run && (m_pos < m_ratio / 2);
    et = m_run && (m_pos == 0);
    ea = m_run;
    er = (m_pend.size() == 0);
    return {ez, et, ea, er};
  endfunction

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic load_idle(input int d);
    EN        = 1'b0;
    DIV       = W'(d);
    CFG_VALID = 1'b1;
    step();
    CFG_VALID = 1'b0;
  endtask

  task automatic go_idle();
    EN        = 1'b0;
    CFG_VALID = 1'b0;
    for (int k = 0; k < 600 && ACTIVE === 1'b1; k++) step();
    n_tests++;
    if (ACTIVE !== 1'b0 || Z !== 1'b0) begin
      n_fail++;
      $display("FAIL go_idle: ACTIVE=%b Z=%b, required ACTIVE=0 Z=0", ACTIVE, Z);
    end
  endtask

  task automatic test_reset();
    RN = 1'b0;
    EN = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({Z, TICK, ACTIVE, CFG_READY} !== 4'b0001) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: Z/TICK/ACTIVE/READY=%b required 0001", i, {Z, TICK, ACTIVE, CFG_READY});
      end
    end
    RN = 1'b1;
    step();
    n_tests++;
    if ({Z, TICK, ACTIVE, CFG_READY} !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_release_first: Z/TICK/ACTIVE/READY=%b required 1111", {Z, TICK, ACTIVE, CFG_READY});
    end
    for (int i = 1; i < 7; i++) begin
      step();
      n_tests++;
      if (Z !== logic'(i % 2 == 0) || TICK !== logic'(i % 2 == 0)) begin
        n_fail++;
        $display("FAIL reset_div2[%0d]: Z=%b TICK=%b required Z=%b TICK=%b", i, Z, TICK, i % 2 == 0, i % 2 == 0);
      end
    end
    go_idle();
  endtask

  task automatic test_pattern(input int d, input int periods);
    int   ticks;
    logic ez, et;
    int   n;
    ticks = 0;
    n = (d < 2) ? 2 : d;
    load_idle(d);
    EN = 1'b1;
    for (int i = 0; i < n * periods; i++) begin
      step();
      ez = logic'((i % n) < n / 2);
      et = logic'((i % n) == 0);
      if (TICK === 1'b1) ticks++;
      n_tests++;
      if (Z !== ez || TICK !== et || ACTIVE !== 1'b1) begin
        n_fail++;
        $display("FAIL pattern_div%0d[%0d]: Z=%b TICK=%b ACTIVE=%b required Z=%b TICK=%b ACTIVE=1", d, i, Z, TICK, ACTIVE, ez, et);
      end
    end
    n_tests++;
    if (ticks != periods) begin
      n_fail++;
      $display("FAIL tick_count_div%0d: got %0d required %0d", d, ticks, periods);
    end
    go_idle();
  endtask

  task automatic test_runtime_change();
    load_idle(4);
    EN = 1'b1;
    step();
    step();
    DIV       = W'(6);
    CFG_VALID = 1'b1;
    step();
    CFG_VALID = 1'b0;
    n_tests++;
    if ({Z, CFG_READY} !== 2'b00) begin
      n_fail++;
      $display("FAIL runtime_accept: Z=%b READY=%b required Z=0 READY=0", Z, CFG_READY);
    end
    step();
    n_tests++;
    if ({Z, TICK, CFG_READY} !== 3'b000) begin
      n_fail++;
      $display("FAIL runtime_old_last: Z/TICK/READY=%b required 000", {Z, TICK, CFG_READY});
    end
    for (int i = 0; i < 7; i++) begin
      step();
      n_tests++;
      if (Z !== logic'((i % 6) < 3) || TICK !== logic'((i % 6) == 0) || CFG_READY !== 1'b1) begin
        n_fail++;
        $display("FAIL runtime_new[%0d]: Z=%b TICK=%b READY=%b required Z=%b TICK=%b READY=1", i, Z, TICK, CFG_READY, (i % 6) < 3, (i % 6) == 0);
      end
    end
    go_idle();
  endtask

  task automatic test_clamp_gate_off();
    test_pattern(0, 2);
    test_pattern(1, 1);
    load_idle(6);
    EN = 1'b1;
    step();
    step();
    EN = 1'b0;
    for (int i = 2; i < 7; i++) begin
      step();
      n_tests++;
      if (i < 6 && (Z !== logic'(i < 3) || ACTIVE !== 1'b1)) begin
        n_fail++;
        $display("FAIL gate_off_drain[%0d]: Z=%b ACTIVE=%b required Z=%b ACTIVE=1", i, Z, ACTIVE, i < 3);
      end else if (i == 6 && {Z, TICK, ACTIVE} !== 3'b000) begin
        n_fail++;
        $display("FAIL gate_off_idle: Z/TICK/ACTIVE=%b required 000", {Z, TICK, ACTIVE});
      end
    end
  endtask

  task automatic test_async_reset(input int at_pos);
    load_idle(8);
    EN = 1'b1;
    for (int i = 0; i <= at_pos; i++) step();
    n_tests++;
    if (Z !== logic'(at_pos < 4)) begin
      n_fail++;
      $display("FAIL async_pre[%0d]: Z=%b required %b", at_pos, Z, at_pos < 4);
    end
    RN = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({Z, TICK, ACTIVE, CFG_READY} !== 4'b0001) begin
      n_fail++;
      $display("FAIL async_immediate[%0d]: Z/TICK/ACTIVE/READY=%b required 0001", at_pos, {Z, TICK, ACTIVE, CFG_READY});
    end
    #2;
    RN = 1'b1;
    EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (Z !== logic'(i % 2 == 0) || CFG_READY !== 1'b1) begin
        n_fail++;
        $display("FAIL async_default_div[%0d]: Z=%b READY=%b required Z=%b READY=1", i, Z, CFG_READY, i % 2 == 0);
      end
    end
    go_idle();
  endtask

  task automatic test_random();
    logic [3:0] exp;
    int         bad;
    bad = 0;
    for (int i = 0; i < 1500; i++) begin
      EN        = ($urandom_range(0, 11) != 0);
      CFG_VALID = ($urandom_range(0, 4) == 0);
      DIV       = W'($urandom_range(0, 11));
      step();
      exp = model_out();
      n_tests++;
      if ({Z, TICK, ACTIVE, CFG_READY} !== exp) begin
        n_fail++;
        bad++;
        if (bad < 10)
          $display("FAIL random[%0d]: Z/TICK/ACTIVE/READY=%b required %b", i, {Z, TICK, ACTIVE, CFG_READY}, exp);
      end
    end
    CFG_VALID = 1'b0;
    go_idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pattern(4, 3);
    test_pattern(5, 2);
    test_runtime_change();
    test_clamp_gate_off();
    test_async_reset(1);
    test_async_reset(5);
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
